// File: rtl/pde_pkg.sv
// Shared types and constants for the priority drain encoder.
// Handshake rule for every port pair: a beat transfers on a rising clk edge where valid && ready.
package pde_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [7:0] PDE_NONE_CODE = 8'hF0;

  localparam logic DIR_MSB = 1'b0;
  localparam logic DIR_LSB = 1'b1;

endpackage

// File: rtl/pde_find_first.sv
// Combinational find-first-set over a vector in a selectable direction,
// plus any-set and exactly-one-set flags.
module pde_find_first
  import pde_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OUT_W = 8
) (
  input  logic [WIDTH-1:0] vec,
  input  logic             dir,
  output logic [OUT_W-1:0] idx,
  output logic             any,
  output logic             single
);

  // Later matches overwrite earlier ones, so the scan order picks the winner.
  always_comb begin
    idx    = '0;
    any    = |vec;
    single = any && ((vec & (vec - WIDTH'(1))) == '0);
    if (dir == DIR_LSB) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) idx = OUT_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) idx = OUT_W'(i);
      end
    end
  end

endmodule

// File: rtl/priority_drain_encoder.sv
// Captures a request vector and emits the index of every set bit, one beat per
// output handshake, in priority order. Optional popcount output: PDE_POPCOUNT_EN.
module priority_drain_encoder
  import pde_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int OUT_W     = 8,
  parameter int NONE_CODE = int'(PDE_NONE_CODE)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_vec,
  input  logic                       in_lsb_first,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_idx,
  output logic                       out_last,
  output logic                       out_none,
  output logic                       busy,
`ifdef PDE_POPCOUNT_EN
  output logic [$clog2(WIDTH+1)-1:0] out_count,
`endif
  output state_t                     dbg_state
);

  localparam logic [OUT_W-1:0] NONE_IDX = OUT_W'(NONE_CODE);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] vec_q;
  logic             dir_q;
  logic [OUT_W-1:0] ff_idx;
  logic             ff_any;
  logic             ff_single;
  logic             accept;
  logic             out_fire;

  pde_find_first #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_find_first (
    .vec    (vec_q),
    .dir    (dir_q),
    .idx    (ff_idx),
    .any    (ff_any),
    .single (ff_single)
  );

  assign accept    = (state_q == IDLE) && in_valid;
  assign out_fire  = (state_q == DRAIN) && out_ready;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // An empty vector is its own last beat, so the drain ends on the first fire.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = DRAIN;
      DRAIN:   if (out_ready && (ff_single || !ff_any)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b1;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_none  = 1'b0;
    if (state_q == DRAIN) begin
      in_ready  = 1'b0;
      busy      = 1'b1;
      out_valid = 1'b1;
      out_none  = !ff_any;
      out_idx   = ff_any ? ff_idx : NONE_IDX;
      out_last  = ff_single || !ff_any;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
      dir_q <= DIR_MSB;
    end else if (accept) begin
      vec_q <= in_vec;
      dir_q <= in_lsb_first;
    end else if (out_fire && ff_any) begin
      vec_q <= vec_q & ~(WIDTH'(1) << ff_idx);
    end
  end

`ifdef PDE_POPCOUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      out_count <= '0;
    else if (accept) out_count <= ($clog2(WIDTH+1))'($countones(in_vec));
  end
`endif

endmodule
